// File: rtl/reg_fifo8.sv
// Register-built show-ahead FIFO: DEPTH words of WIDTH bits with pointer/count bookkeeping
// and sticky overflow/underflow flags. The head word is always visible on out.
module reg_fifo8 #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] out,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             ovf,
  output logic             udf
);

  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_count;
  logic             r_ovf;
  logic             r_udf;

  logic             w_full;
  logic             w_empty;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic [DEPTH-1:0] w_load;

  assign w_full    = (r_count == FullCount);
  assign w_empty   = (r_count == '0);
  // Reset discards requests, so nothing is accepted in a reset cycle.
  assign w_push_ok = ~reset & push & (~w_full | pop);
  assign w_pop_ok  = ~reset & pop & ~w_empty;

  always_comb begin
    w_load       = '0;
    w_load[r_wp] = w_push_ok;
  end

  // Storage carries no reset; only the word selected by wp is ever loaded.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_load[i]) r_mem[i] <= in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      if (w_push_ok) r_wp <= r_wp + AW'(1);
      if (w_pop_ok)  r_rp <= r_rp + AW'(1);
      unique case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
      if (push & w_full & ~pop) r_ovf <= 1'b1;
      if (pop & w_empty)        r_udf <= 1'b1;
    end
  end

  assign out   = w_empty ? '0 : r_mem[r_rp];
  assign full  = w_full;
  assign empty = w_empty;
  assign count = r_count;
  assign ovf   = r_ovf;
  assign udf   = r_udf;

endmodule

// File: doc/reg_fifo8.md
# reg_fifo8

Register-built first-in/first-out buffer in the project-03 sequential layer. Storage is DEPTH words of WIDTH-bit registers, each bit a load-enabled `Bit` cell. It takes words from an upstream producer and presents them, oldest first, to a downstream consumer. Read is show-ahead: the head word is always visible on `out`.

## Interface
- WIDTH, 16, data word width in bits
- DEPTH, 8, number of storage words; power of two, 2..64
- AW, $clog2(DEPTH), pointer width (derived, do not override)
- clk  input  1  rising-edge clock for all state
- reset  input  1  synchronous, active-high; clears pointers, count and error flags on the next rising `clk`
- in  input  WIDTH  write data, sampled on a `clk` edge when a push is accepted
- push  input  1  write request
- pop  input  1  read request; retires the current head word
- out  output  WIDTH  head word; 0 when empty
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- count  output  AW+1  number of stored words, 0..DEPTH
- ovf  output  1  sticky: a push was refused because the FIFO was full
- udf  output  1  sticky: a pop was refused because the FIFO was empty

## Operation
- State: write pointer `wp` (AW bits), read pointer `rp` (AW bits), `count` (AW+1 bits), `ovf`, `udf`, and the storage array.
- Storage words carry no reset. Only their contents' visibility is controlled, through `out` masking.
- Accept rules, evaluated against pre-edge state:
  - push_ok = push & (~full | pop)
  - pop_ok = pop & ~empty
- push_ok: write `in` to mem[wp]. The only storage load enable is the one decoded from `wp`; all other words hold. Then wp <= wp+1, modulo DEPTH.
- pop_ok: rp <= rp+1, modulo DEPTH.
- count update:
  - +1 on push_ok only
  - −1 on pop_ok only
  - unchanged when both or neither
- Full with push and pop together: both are accepted. The head retires and the new word goes into the freed slot. `count` stays DEPTH and `ovf` is not set.
- Empty with push and pop together: the pop is refused and `udf` is set. The push is accepted and `count` becomes 1.
- Refused push (push & full & ~pop): `ovf` <= 1, and storage and pointers are unchanged.
- Refused pop (pop & empty): `udf` <= 1, and pointers are unchanged.
- Only `reset` clears `ovf` and `udf`.
- `out` = empty ? 0 : mem[rp]. This is a combinational mux from the registered state.
- `full` and `empty` are combinational decodes of `count`.
- Pointer wrap is plain modulo-DEPTH arithmetic. `count` alone distinguishes full from empty when wp == rp.

## Timing
- Every state change happens on the rising `clk` edge. No combinational path runs from `push`, `pop` or `in` to any output.
- Write-to-read latency is 1 cycle. A word pushed at edge N appears on `out` after edge N if the FIFO was empty, and `empty` drops after the same edge.
- After a pop at edge N, `out` shows the next word after edge N.
- `reset` has priority over `push` and `pop` in the same cycle; those requests are discarded.
- On the edge where `reset` is sampled high, and after it:
  - wp = rp = 0, count = 0
  - empty = 1, full = 0
  - ovf = udf = 0
  - out = 0
- Reset asserted mid-operation discards all stored words logically. Storage contents are left as-is but are unreachable.
- Outputs before the first reset are undefined. Benches must apply `reset` for at least 1 cycle first.
- Inputs must be stable around the rising edge. Benches drive them on the falling edge or at half-period offsets, with a 2-time-unit clock period.

## Test plan
- Reset: after 1 cycle of reset = 1, expect count = 0, empty = 1, full = 0, out = 0, ovf = udf = 0.
- Order: push 0x0001, 0x0002, 0x0003 on consecutive edges.
  - Expect count = 3 and out = 0x0001.
  - Pop three times: out goes to 0x0002, then 0x0003, then 0 with empty = 1.
- Fill and overflow: push 0x00A0..0x00A7 (8 words). Expect full = 1 and count = 8.
  - A 9th push of 0xFFFF is refused: ovf = 1, count = 8, out = 0x00A0.
  - Draining yields 0x00A0..0x00A7 in order; 0xFFFF never appears.
- Underflow and simultaneous ops:
  - pop on empty: udf = 1, count = 0.
  - push 0x1234 with pop on empty: count = 1, out = 0x1234.
  - From full, push 0xBEEF with pop: count = 8, ovf = 0, the old head is gone, and 0xBEEF is read out last.
- Wrap-around: run 20 cycles of push+pop interleaved at count = 3 with incrementing data. Every value must come out exactly once, in order, across multiple pointer wraps.
- Mid-operation reset: with count = 5, ovf = 1 and push = 1, assert reset.
  - Expect count = 0, empty = 1, ovf = 0 on the next edge.
  - A subsequent push of 0x0055 gives out = 0x0055.
